rip_csr_trap: RTL and testbench

//  Machine-mode CSR file and trap sequencer for the RIP core. It sits beside execute/writeback and owns

---
 rtl/rip_config.sv | 34 +++
 rtl/rip_csr_trap.sv | 142 ++++++++++++++
 tb/tb_rip_csr_trap.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rip_config.sv
// Shared configuration for the RIP core: reset PC, machine-mode CSR
// addresses, trap cause codes and the CSR/trap sequencer enums.
package rip_config;

    localparam int unsigned RIP_XLEN = 32;

    localparam logic [31:0] START_ADDR          = 32'h0000_8000;
    localparam logic [31:0] MTVEC_RESET_DEFAULT = START_ADDR;

    localparam logic [11:0] CSR_MTVEC  = 12'h305;
    localparam logic [11:0] CSR_MEPC   = 12'h341;
    localparam logic [11:0] CSR_MCAUSE = 12'h342;

    localparam logic [3:0] CAUSE_ILLEGAL_INST = 4'd2;
    localparam logic [3:0] CAUSE_ECALL_M      = 4'd11;

    typedef enum logic [1:0] {
        CSR_OP_RSVD = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_REDIRECT = 1'b1
    } trap_state_e;

    // Only the three machine-mode trap CSRs exist in this core.
    function automatic logic csr_addr_legal(input logic [11:0] addr);
        return (addr == CSR_MTVEC) || (addr == CSR_MEPC) || (addr == CSR_MCAUSE);
    endfunction

endpackage

// File: rtl/rip_csr_trap.sv
// Machine-mode CSR file (mtvec/mepc/mcause) and trap/mret redirect sequencer.
//
//  state       | meaning
//  ------------+-------------------------------------------------------------
//  ST_IDLE     | accepting CSR ops, traps and mret from execute
//  ST_REDIRECT | redirect pulse to fetch is out; all inputs ignored, busy=1
import rip_config::*;

module rip_csr_trap #(
    parameter int unsigned      XLEN        = RIP_XLEN,
    parameter logic [XLEN-1:0]  MTVEC_RESET = XLEN'(MTVEC_RESET_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            csr_valid,
    input  logic [1:0]      csr_op,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    input  logic [XLEN-1:0] inst_pc,
    input  logic            ecall,
    input  logic            exc_valid,
    input  logic [3:0]      exc_cause,
    input  logic            mret,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic            busy
);

    // mtvec and mepc are word aligned; bits [1:0] never hold a one.
    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    trap_state_e     state;
    trap_state_e     state_next;

    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mepc;
    logic [XLEN-1:0] mcause;

    logic [XLEN-1:0] wr_val;
    logic            illegal;
    logic            take_trap;
    logic            take_mret;
    logic            do_write;
    logic [3:0]      trap_cause;

    assign busy = (state == ST_REDIRECT);

    // Read mux: old value of the addressed CSR, independent of csr_valid.
    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            CSR_MTVEC:  csr_rdata = mtvec;
            CSR_MEPC:   csr_rdata = mepc;
            CSR_MCAUSE: csr_rdata = mcause;
            default:    csr_rdata = '0;
        endcase
    end

    // Write-data ALU: new value from the old value and the operand.
    always_comb begin
        wr_val = csr_rdata;
        case (csr_op_e'(csr_op))
            CSR_OP_RW: wr_val = csr_wdata;
            CSR_OP_RS: wr_val = csr_rdata | csr_wdata;
            CSR_OP_RC: wr_val = csr_rdata & ~csr_wdata;
            default:   wr_val = csr_rdata;
        endcase
    end

    // Request arbitration and next state: illegal > ecall > exc > mret > write.
    always_comb begin
        illegal    = 1'b0;
        take_trap  = 1'b0;
        take_mret  = 1'b0;
        do_write   = 1'b0;
        trap_cause = CAUSE_ILLEGAL_INST;
        state_next = state;

        case (state)
            ST_IDLE: begin
                illegal = csr_valid &&
                          ((csr_op_e'(csr_op) == CSR_OP_RSVD) || !csr_addr_legal(csr_addr));
                if (illegal) begin
                    take_trap  = 1'b1;
                    trap_cause = CAUSE_ILLEGAL_INST;
                end else if (ecall) begin
                    take_trap  = 1'b1;
                    trap_cause = CAUSE_ECALL_M;
                end else if (exc_valid) begin
                    take_trap  = 1'b1;
                    trap_cause = exc_cause;
                end else if (mret) begin
                    take_mret  = 1'b1;
                end else if (csr_valid) begin
                    do_write   = 1'b1;
                end

                if (take_trap || take_mret) begin
                    state_next = ST_REDIRECT;
                end
            end
            ST_REDIRECT: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State, CSRs and the registered redirect pulse/target.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            mtvec       <= MTVEC_RESET & ALIGN_MASK;
            mepc        <= '0;
            mcause      <= '0;
            redirect    <= 1'b0;
            redirect_pc <= '0;
        end else begin
            state    <= state_next;
            redirect <= take_trap || take_mret;

            if (take_trap) begin
                redirect_pc <= mtvec;
                mepc        <= inst_pc & ALIGN_MASK;
                mcause      <= {{(XLEN-4){1'b0}}, trap_cause};
            end else if (take_mret) begin
                redirect_pc <= mepc;
            end else if (do_write) begin
                case (csr_addr)
                    CSR_MTVEC:  mtvec  <= wr_val & ALIGN_MASK;
                    CSR_MEPC:   mepc   <= wr_val & ALIGN_MASK;
                    CSR_MCAUSE: mcause <= wr_val;
                    default:    ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rip_csr_trap.sv
// Self-checking bench for rip_csr_trap: directed vector table, a randomized
// run against a CSR/trap reference model, and a reset-during-redirect sequence.
module tb_rip_csr_trap;

    logic        clk;
    logic        rst;
    logic        csr_valid;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic [31:0] inst_pc;
    logic        ecall;
    logic        exc_valid;
    logic [3:0]  exc_cause;
    logic        mret;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    rip_csr_trap dut (
        .clk         (clk),
        .rst         (rst),
        .csr_valid   (csr_valid),
        .csr_op      (csr_op),
        .csr_addr    (csr_addr),
        .csr_wdata   (csr_wdata),
        .csr_rdata   (csr_rdata),
        .inst_pc     (inst_pc),
        .ecall       (ecall),
        .exc_valid   (exc_valid),
        .exc_cause   (exc_cause),
        .mret        (mret),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [1:0]  op;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] pc;
        logic        ec;
        logic        ex;
        logic [3:0]  cause;
        logic        mr;
        logic [31:0] exp_rdata;
        logic        exp_redir;
        logic [31:0] exp_rpc;
        logic        exp_busy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic valid, logic [1:0] op, logic [11:0] addr, logic [31:0] wdata,
                                logic [31:0] pc, logic ec, logic ex, logic [3:0] cause, logic mr,
                                logic [31:0] rd, logic red, logic [31:0] rpc, logic bsy);
        vec_t v;
        v.valid = valid; v.op = op; v.addr = addr; v.wdata = wdata; v.pc = pc;
        v.ec = ec; v.ex = ex; v.cause = cause; v.mr = mr;
        v.exp_rdata = rd; v.exp_redir = red; v.exp_rpc = rpc; v.exp_busy = bsy;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic valid, input logic [1:0] op, input logic [11:0] addr,
                         input logic [31:0] wdata, input logic [31:0] pc, input logic ec,
                         input logic ex, input logic [3:0] cause, input logic mr);
        csr_valid = valid; csr_op = op; csr_addr = addr; csr_wdata = wdata;
        inst_pc = pc; ecall = ec; exc_valid = ex; exc_cause = cause; mret = mr;
    endtask

    task automatic do_reset();
        drive(1'b0, 2'b00, 12'h305, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 1'b0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Reference model state: CSR contents by address; absence means illegal.
    logic [31:0] csr_m [int];
    bit          m_busy;

    initial begin
        logic [31:0] exp_rd;
        logic        e_red;
        logic [31:0] e_rpc;
        logic        r_valid, r_ec, r_ex, r_mr, r_ill;
        logic [1:0]  r_op;
        logic [11:0] r_addr;
        logic [31:0] r_wd, r_pc, r_old, r_new;
        logic [3:0]  r_cause;

        //  valid op    addr    wdata         pc            ec ex cause mr  rdata         red rpc           busy
        tbl.push_back(mk(0, 2'b00, 12'h305, 32'h0,        32'h0,       0, 0, 4'h0, 0, 32'h0000_8000, 0, 32'h0,        0));
        tbl.push_back(mk(0, 2'b00, 12'h341, 32'h0,        32'h0,       0, 0, 4'h0, 0, 32'h0,         0, 32'h0,        0));
        tbl.push_back(mk(0, 2'b00, 12'h342, 32'h0,        32'h0,       0, 0, 4'h0, 0, 32'h0,         0, 32'h0,        0));
        tbl.push_back(mk(1, 2'b01, 12'h305, 32'h0000_1003, 32'h0,      0, 0, 4'h0, 0, 32'h0000_8000, 0, 32'h0,        0));
        tbl.push_back(mk(1, 2'b10, 12'h305, 32'h0000_0010, 32'h0,      0, 0, 4'h0, 0, 32'h0000_1000, 0, 32'h0,        0));
        tbl.push_back(mk(1, 2'b11, 12'h305, 32'h0000_1000, 32'h0,      0, 0, 4'h0, 0, 32'h0000_1010, 0, 32'h0,        0));
        tbl.push_back(mk(0, 2'b00, 12'h305, 32'h0,        32'h0,       0, 0, 4'h0, 0, 32'h0000_0010, 0, 32'h0,        0));
        tbl.push_back(mk(0, 2'b00, 12'h305, 32'h0,        32'h8010,    1, 0, 4'h0, 0, 32'h0000_0010, 1, 32'h0000_0010, 1));
        tbl.push_back(mk(0, 2'b00, 12'h341, 32'h0,        32'h0,       0, 0, 4'h0, 0, 32'h0000_8010, 0, 32'h0,        0));
        tbl.push_back(mk(0, 2'b00, 12'h342, 32'h0,        32'h0,       0, 0, 4'h0, 0, 32'd11,        0, 32'h0,        0));
        tbl.push_back(mk(0, 2'b00, 12'h342, 32'h0,        32'h0,       0, 0, 4'h0, 1, 32'd11,        1, 32'h0000_8010, 1));
        tbl.push_back(mk(0, 2'b00, 12'h342, 32'h0,        32'h0,       0, 0, 4'h0, 0, 32'd11,        0, 32'h0,        0));
        tbl.push_back(mk(1, 2'b01, 12'h300, 32'hDEAD_BEEF, 32'h8020,   0, 0, 4'h0, 0, 32'h0,         1, 32'h0000_0010, 1));
        tbl.push_back(mk(0, 2'b00, 12'h341, 32'h0,        32'h0,       0, 0, 4'h0, 0, 32'h0000_8020, 0, 32'h0,        0));
        tbl.push_back(mk(0, 2'b00, 12'h342, 32'h0,        32'h0,       0, 0, 4'h0, 0, 32'd2,         0, 32'h0,        0));
        tbl.push_back(mk(1, 2'b01, 12'h341, 32'h0000_1234, 32'h8030,   1, 0, 4'h0, 0, 32'h0000_8020, 1, 32'h0000_0010, 1));
        tbl.push_back(mk(0, 2'b00, 12'h341, 32'h0,        32'h0,       0, 0, 4'h0, 0, 32'h0000_8030, 0, 32'h0,        0));
        tbl.push_back(mk(0, 2'b00, 12'h342, 32'h0,        32'h0,       0, 0, 4'h0, 0, 32'd11,        0, 32'h0,        0));
        tbl.push_back(mk(0, 2'b00, 12'h305, 32'h0,        32'h8040,    1, 0, 4'h0, 1, 32'h0000_0010, 1, 32'h0000_0010, 1));
        tbl.push_back(mk(1, 2'b01, 12'h305, 32'h0000_2000, 32'h9000,   1, 0, 4'h0, 0, 32'h0000_0010, 0, 32'h0,        0));
        tbl.push_back(mk(0, 2'b00, 12'h305, 32'h0,        32'h0,       0, 0, 4'h0, 0, 32'h0000_0010, 0, 32'h0,        0));
        tbl.push_back(mk(0, 2'b00, 12'h341, 32'h0,        32'h0,       0, 0, 4'h0, 0, 32'h0000_8040, 0, 32'h0,        0));
        tbl.push_back(mk(1, 2'b01, 12'h305, 32'h0000_4000, 32'h0,      0, 0, 4'h0, 0, 32'h0000_0010, 0, 32'h0,        0));
        tbl.push_back(mk(0, 2'b00, 12'h305, 32'h0,        32'h8050,    0, 1, 4'h5, 0, 32'h0000_4000, 1, 32'h0000_4000, 1));
        tbl.push_back(mk(0, 2'b00, 12'h342, 32'h0,        32'h0,       0, 0, 4'h0, 0, 32'd5,         0, 32'h0,        0));
        tbl.push_back(mk(1, 2'b00, 12'h305, 32'h0000_0FF0, 32'h8062,   0, 0, 4'h0, 0, 32'h0000_4000, 1, 32'h0000_4000, 1));
        tbl.push_back(mk(0, 2'b00, 12'h341, 32'h0,        32'h0,       0, 0, 4'h0, 0, 32'h0000_8060, 0, 32'h0,        0));
        tbl.push_back(mk(0, 2'b00, 12'h342, 32'h0,        32'h0,       0, 0, 4'h0, 0, 32'd2,         0, 32'h0,        0));
        tbl.push_back(mk(1, 2'b01, 12'h305, 32'h0000_7000, 32'h0,      0, 0, 4'h0, 1, 32'h0000_4000, 1, 32'h0000_8060, 1));
        tbl.push_back(mk(0, 2'b00, 12'h305, 32'h0,        32'h0,       0, 0, 4'h0, 0, 32'h0000_4000, 0, 32'h0,        0));
        tbl.push_back(mk(0, 2'b00, 12'h342, 32'h0,        32'h0,       0, 0, 4'h0, 0, 32'd2,         0, 32'h0,        0));

        rst = 1'b1;
        do_reset();
        check("reset_redirect", {31'b0, redirect}, 32'h0);
        check("reset_redirect_pc", redirect_pc, 32'h0);
        check("reset_busy", {31'b0, busy}, 32'h0);

        // Directed vector table.
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i].valid, tbl[i].op, tbl[i].addr, tbl[i].wdata, tbl[i].pc,
                  tbl[i].ec, tbl[i].ex, tbl[i].cause, tbl[i].mr);
            #1;
            check($sformatf("vec%0d_rdata", i), csr_rdata, tbl[i].exp_rdata);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_redirect", i), {31'b0, redirect}, {31'b0, tbl[i].exp_redir});
            check($sformatf("vec%0d_busy", i), {31'b0, busy}, {31'b0, tbl[i].exp_busy});
            if (tbl[i].exp_redir)
                check($sformatf("vec%0d_redirect_pc", i), redirect_pc, tbl[i].exp_rpc);
        end

        // Reset asserted while in REDIRECT.
        @(negedge clk);
        drive(0, 2'b00, 12'h305, 32'h0, 32'h0000_A004, 1, 0, 4'h0, 0);
        @(posedge clk);
        #1;
        check("rstmid_redirect_before", {31'b0, redirect}, 32'h1);
        drive(0, 2'b00, 12'h305, 32'h0, 32'h0, 0, 0, 4'h0, 0);
        rst = 1'b1;
        #1;
        check("rstmid_redirect", {31'b0, redirect}, 32'h0);
        check("rstmid_busy", {31'b0, busy}, 32'h0);
        check("rstmid_redirect_pc", redirect_pc, 32'h0);
        check("rstmid_mtvec", csr_rdata, 32'h0000_8000);
        csr_addr = 12'h341;
        #1;
        check("rstmid_mepc", csr_rdata, 32'h0);
        csr_addr = 12'h342;
        #1;
        check("rstmid_mcause", csr_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rstmid_after_redirect", {31'b0, redirect}, 32'h0);

        // Randomized run against the reference model.
        do_reset();
        csr_m.delete();
        csr_m[12'h305] = 32'h0000_8000;
        csr_m[12'h341] = 32'h0;
        csr_m[12'h342] = 32'h0;
        m_busy = 0;

        for (int i = 0; i < 1500; i++) begin
            r_valid = ($urandom_range(0, 1) == 1);
            r_op    = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 4))
                0: r_addr = 12'h305;
                1: r_addr = 12'h341;
                2: r_addr = 12'h342;
                3: r_addr = 12'h300;
                default: r_addr = 12'($urandom);
            endcase
            r_wd    = $urandom;
            r_pc    = $urandom;
            r_ec    = ($urandom_range(0, 7) == 0);
            r_ex    = ($urandom_range(0, 7) == 0);
            r_cause = 4'($urandom);
            r_mr    = ($urandom_range(0, 7) == 0);
            // Keep most CSR ops legal so the write path gets exercised.
            if (r_op == 2'b00 && $urandom_range(0, 3) != 0) r_op = 2'b01;

            @(negedge clk);
            drive(r_valid, r_op, r_addr, r_wd, r_pc, r_ec, r_ex, r_cause, r_mr);
            #1;
            exp_rd = csr_m.exists(int'(r_addr)) ? csr_m[int'(r_addr)] : 32'h0;
            check("rand_rdata", csr_rdata, exp_rd);

            e_red = 0;
            e_rpc = 32'h0;
            if (m_busy) begin
                m_busy = 0;
            end else begin
                r_ill = r_valid && (r_op == 2'b00 || !csr_m.exists(int'(r_addr)));
                if (r_ill || r_ec || r_ex) begin
                    e_red = 1;
                    e_rpc = csr_m[12'h305];
                    csr_m[12'h341] = r_pc & ~32'h3;
                    csr_m[12'h342] = r_ill ? 32'd2 : (r_ec ? 32'd11 : {28'h0, r_cause});
                    m_busy = 1;
                end else if (r_mr) begin
                    e_red = 1;
                    e_rpc = csr_m[12'h341];
                    m_busy = 1;
                end else if (r_valid) begin
                    r_old = csr_m[int'(r_addr)];
                    if (r_op == 2'b01)      r_new = r_wd;
                    else if (r_op == 2'b10) r_new = r_old | r_wd;
                    else                    r_new = r_old & ~r_wd;
                    if (r_addr != 12'h342) r_new = r_new & ~32'h3;
                    csr_m[int'(r_addr)] = r_new;
                end
            end

            @(posedge clk);
            #1;
            check("rand_redirect", {31'b0, redirect}, {31'b0, e_red});
            check("rand_busy", {31'b0, busy}, {31'b0, m_busy});
            if (e_red)
                check("rand_redirect_pc", redirect_pc, e_rpc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
